// File: rtl/sample_sequencer_pkg.sv
// Shared constants for the phase-sampling run controller: sampler address map and FSM encoding.
package sample_sequencer_pkg;

  localparam logic [31:0] PHASE_ADDR_BASE = 32'h0000_4000;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_FREEZE = 3'd3;
  localparam logic [2:0] S_ADDR   = 3'd4;
  localparam logic [2:0] S_LOAD   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  // Byte address of phase counter idx; the add wraps at 32 bits.
  function automatic logic [31:0] phase_addr(input logic [31:0] idx);
    return PHASE_ADDR_BASE + (idx << 2);
  endfunction

endpackage

// File: rtl/sample_sequencer_run_timer.sv
// Loadable down-counter; expire pulses on the last enabled cycle of the loaded count.
module run_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expire_o = en_i && (count_q == W'(1));

endmodule

// File: rtl/sample_sequencer.sv
// Run controller: arms the sampler for a timed window, freezes it, then streams all N
// phase counters out over a valid/ready port.
//
//   state  | meaning
//   IDLE   | waiting for start, sampler frozen
//   ARM    | one low cycle so the sampler sees a clean rstn rising edge
//   RUN    | sampling window, sample_rstn high for run_cycles cycles
//   FREEZE | sampler counters held
//   ADDR   | rd_addr settling for the current idx
//   LOAD   | word presented, waiting for out_ready
//   DONE   | one-cycle done pulse
module sample_sequencer
  import sample_sequencer_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      run_cycles,
  output logic             sample_rstn,
  output logic [31:0]      rd_addr,
  input  logic [31:0]      phase,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy,
  output logic             done
);

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             sample_rstn_q, busy_q, done_q;
  logic [31:0]      rd_addr_q;
  logic             timer_load, timer_expire;
  logic [31:0]      timer_val;

  // A zero-length window would never expire, so it is stretched to one cycle.
  assign timer_val = (run_cycles == 32'd0) ? 32'd1 : run_cycles;

  // Loaded on the accepted start and held through ARM, so the window length is latched there.
  run_timer #(.W(32)) u_run_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .en_i       (state_q == S_RUN),
    .load_val_i (timer_val),
    .expire_o   (timer_expire)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    timer_load  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          timer_load = 1'b1;
          idx_d      = '0;
          state_d    = S_ARM;
        end
      end
      S_ARM:    state_d = S_RUN;
      S_RUN:    if (timer_expire) state_d = S_FREEZE;
      S_FREEZE: state_d = S_ADDR;
      S_ADDR: begin
        out_data_d  = phase;
        out_idx_d   = idx_q;
        out_valid_d = 1'b1;
        state_d     = S_LOAD;
      end
      S_LOAD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == IDX_W'(N - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_ADDR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d     = S_IDLE;
      idx_d       = '0;
      out_valid_d = 1'b0;
      timer_load  = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_idx_q     <= '0;
      sample_rstn_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_addr_q     <= PHASE_ADDR_BASE;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_idx_q     <= out_idx_d;
      sample_rstn_q <= (state_d == S_RUN);
      busy_q        <= (state_d != S_IDLE);
      done_q        <= (state_d == S_DONE);
      rd_addr_q     <= phase_addr(32'(idx_d));
    end
  end

  assign sample_rstn = sample_rstn_q;
  assign rd_addr     = rd_addr_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_idx     = out_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed/randomized bench for sample_sequencer with a behavioural sampler and readout model.
module tb_sample_sequencer;
  import sample_sequencer_pkg::*;

  localparam int N     = 3;
  localparam int IDX_W = 2;

  logic             clk, rst, start, abort, out_ready;
  logic [31:0]      run_cycles, rd_addr, phase, out_data;
  logic             sample_rstn, out_valid, busy, done;
  logic [IDX_W-1:0] out_idx;
  logic [31:0]      cnt [N];

  int total = 0;
  int bad   = 0;

  sample_sequencer #(.N(N), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .run_cycles  (run_cycles),
    .sample_rstn (sample_rstn),
    .rd_addr     (rd_addr),
    .phase       (phase),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sampler: counter k sits at byte address base + 4k.
  always_comb begin
    phase = 32'hBAD0_BAD0;
    for (int k = 0; k < N; k++)
      if (rd_addr == PHASE_ADDR_BASE + 32'(k) * 32'd4) phase = cnt[k];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_rstn"}, 32'(sample_rstn), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic quiet_window(input string tag);
    int nd, nb;
    nd = 0; nb = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
    chk({tag, "_no_done"}, 32'(nd), 0);
    chk({tag, "_stay_idle"}, 32'(nb), 0);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 300 && !out_valid; i++) @(negedge clk);
    chk({tag, "_reach_load"}, 32'(out_valid), 1);
  endtask

  task automatic wait_rstn(input string tag);
    for (int i = 0; i < 50 && !sample_rstn; i++) @(negedge clk);
    chk({tag, "_reach_run"}, 32'(sample_rstn), 1);
  endtask

  task automatic pulse_start(input logic [31:0] rc);
    start = 1'b1; run_cycles = rc;
    @(negedge clk);
    start = 1'b0; run_cycles = $urandom;
  endtask

  // Full run observed cycle by cycle; expectations come from window length and cnt[].
  task automatic run_seq(input string tag, input logic [31:0] rc, input bit rand_ready,
                         input bit inject);
    int hi, rises, ndone, nwords, stall;
    bit prev_hi, pend, finished;
    logic [31:0] pd, pi, win;
    hi = 0; rises = 0; ndone = 0; nwords = 0; stall = 0;
    prev_hi = 0; pend = 0; finished = 0; pd = 0; pi = 0;
    win = (rc == 0) ? 32'd1 : rc;
    pulse_start(rc);
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (sample_rstn) begin
        hi++;
        if (!prev_hi) rises++;
      end
      prev_hi = sample_rstn;
      if (pend) begin
        chk({tag, "_stall_valid"}, 32'(out_valid), 1);
        chk({tag, "_stall_data"}, out_data, pd);
        chk({tag, "_stall_idx"}, 32'(out_idx), pi);
      end
      if (done) begin
        ndone++;
        chk({tag, "_busy_at_done"}, 32'(busy), 1);
      end else if (ndone > 0) begin
        chk({tag, "_busy_after_done"}, 32'(busy), 0);
        finished = 1;
      end
      start = inject && sample_rstn && (hi == 2);
      if (start) run_cycles = win + 32'd14;
      out_ready = rand_ready ? (stall == 0) : 1'b1;
      if (out_valid && out_ready) begin
        chk({tag, "_word_idx"}, 32'(out_idx), 32'(nwords));
        chk({tag, "_word_data"}, out_data, (nwords < N) ? cnt[nwords] : 32'hFFFF_FFFF);
        chk({tag, "_rd_addr"}, rd_addr, PHASE_ADDR_BASE + 32'(nwords) * 32'd4);
        nwords++;
        pend = 0;
        stall = $urandom_range(0, 10);
      end else begin
        if (out_valid && stall > 0) stall--;
        pend = out_valid;
      end
      pd = out_data;
      pi = 32'(out_idx);
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_finished"}, 32'(finished), 1);
    chk({tag, "_window"}, 32'(hi), win);
    chk({tag, "_rstn_rises"}, 32'(rises), 1);
    chk({tag, "_words"}, 32'(nwords), N);
    chk({tag, "_done_pulses"}, 32'(ndone), 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; run_cycles = 32'd0;
    for (int k = 0; k < N; k++) cnt[k] = $urandom;
    #3;
    chk("rst_rstn", 32'(sample_rstn), 0);
    chk("rst_addr", rd_addr, PHASE_ADDR_BASE);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", 32'(out_idx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_seq("t1", 32'd5, 1'b0, 1'b0);

    cnt[0] = 32'd7; cnt[1] = 32'd0; cnt[2] = 32'd42;
    run_seq("t2", 32'd3, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) cnt[k] = $urandom;
      run_seq("t2r", $urandom_range(1, 9), 1'b1, 1'b0);
    end

    run_seq("t3", 32'd0, 1'b1, 1'b0);

    // Abort two cycles into RUN.
    pulse_start(32'd10);
    wait_rstn("t4a");
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_idle("t4a");
    quiet_window("t4a");

    // Abort while a word is stalled in LOAD.
    out_ready = 1'b0;
    pulse_start(32'd2);
    wait_valid("t4b");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_idle("t4b");
    out_ready = 1'b1;
    quiet_window("t4b");
    run_seq("t4c", 32'd4, 1'b0, 1'b0);

    run_seq("t5", 32'd6, 1'b0, 1'b1);

    start = 1'b1; abort = 1'b1; run_cycles = 32'd3;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk_idle("t5b");
    quiet_window("t5b");

    // Asynchronous reset between clock edges while a word is presented.
    out_ready = 1'b0;
    pulse_start(32'd3);
    wait_valid("t6");
    #2 rst = 1'b1;
    #1;
    chk("t6_rstn", 32'(sample_rstn), 0);
    chk("t6_addr", rd_addr, PHASE_ADDR_BASE);
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_data", out_data, 0);
    chk("t6_idx", 32'(out_idx), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) cnt[k] = $urandom;
    run_seq("t6b", 32'd2, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
